// File: rtl/dualrail_chan_source.sv
// Clocked-to-QDI bridge: valid/ready FIFO feeding a 4-phase
// dual-rail channel, with enable synchronizer and replay mode.
module dualrail_chan_source #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int E_ACTIVE = 1,
  parameter int SYNC     = 2,
  parameter int CNTW     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             loop_en,
  output logic [WIDTH-1:0] d_t,
  output logic [WIDTH-1:0] d_f,
  input  logic             e,
  output logic             busy,
  output logic [CNTW-1:0]  tok_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic E_LVL = (E_ACTIVE != 0);
  localparam logic [AW:0] P_ONE = 1;
  localparam logic [CNTW-1:0] C_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    NEUT
  } state_t;

  state_t           state;
  logic [SYNC-1:0]  sync_q;
  logic             e_s;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rp;
  logic [AW:0]      cur_ptr;
  logic [AW:0]      head_ptr;
  logic [AW:0]      nxt_rp;
  logic             loop_act;
  logic             cur_loop;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             done;

  // Bring the receiver enable into the clock domain, reset to "not ready"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC{~E_LVL}};
    else        sync_q <= {sync_q[SYNC-2:0], e};
  end

  assign e_s = ~(sync_q[SYNC-1] ^ E_LVL);

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign in_ready = rst_n & ~full & ~loop_en;
  assign push     = in_valid & in_ready;
  assign done     = (state == DATA) & ~e_s;
  assign pop      = done & ~cur_loop;

  assign head_ptr = (loop_en & loop_act) ? rp : rd_ptr;
  assign nxt_rp   = cur_ptr + P_ONE;

  assign busy = (state != IDLE) | ~empty;

  // FIFO storage, written on accepted pushes
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // Handshake FSM, FIFO pointers, replay pointer and token counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      d_t       <= '0;
      d_f       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rp        <= '0;
      cur_ptr   <= '0;
      loop_act  <= 1'b0;
      cur_loop  <= 1'b0;
      tok_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      unique case (state)
        IDLE: begin
          loop_act <= loop_en;
          if (loop_en & ~loop_act) rp <= rd_ptr;
          if (e_s & ~empty) begin
            state    <= DATA;
            d_t      <= mem[head_ptr[AW-1:0]];
            d_f      <= ~mem[head_ptr[AW-1:0]];
            cur_ptr  <= head_ptr;
            cur_loop <= loop_en;
          end
        end
        DATA: begin
          if (!e_s) begin
            state     <= NEUT;
            d_t       <= '0;
            d_f       <= '0;
            tok_count <= tok_count + C_ONE;
            if (cur_loop)
              rp <= (nxt_rp == wr_ptr) ? rd_ptr : nxt_rp;
          end
        end
        NEUT: begin
          if (e_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dualrail_chan_source.sv
// Directed bench for dualrail_chan_source: reset, single token,
// backpressure, replay, enable polarity and mid-handshake abort.
module tb_dualrail_chan_source;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        loop_en;
  logic [3:0]  d_t;
  logic [3:0]  d_f;
  logic        e;
  logic        busy;
  logic [15:0] tok_count;

  logic        v2;
  logic        rdy2;
  logic [3:0]  data2;
  logic        loop2;
  logic [3:0]  dt2;
  logic [3:0]  df2;
  logic        e2;
  logic        busy2;
  logic [15:0] tok2;

  int total = 0;
  int bad   = 0;
  int exp_tok = 0;

  always #5 clk = ~clk;

  dualrail_chan_source #(
    .WIDTH(4), .DEPTH(8), .E_ACTIVE(1), .SYNC(2), .CNTW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .loop_en(loop_en), .d_t(d_t), .d_f(d_f), .e(e),
    .busy(busy), .tok_count(tok_count)
  );

  dualrail_chan_source #(
    .WIDTH(4), .DEPTH(8), .E_ACTIVE(0), .SYNC(2), .CNTW(16)
  ) dut_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(rdy2), .in_data(data2),
    .loop_en(loop2), .d_t(dt2), .d_f(df2), .e(e2),
    .busy(busy2), .tok_count(tok2)
  );

  // dual-rail exclusivity on both channels, every cycle
  always @(negedge clk) begin
    total++;
    if (((d_t & d_f) !== 4'h0) || ((dt2 & df2) !== 4'h0)) begin
      bad++;
      $display("FAIL excl: dt=%h df=%h dt2=%h df2=%h, want no overlap",
               d_t, d_f, dt2, df2);
    end
  end

  task automatic push_word(input logic [3:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_token(output logic [3:0] gt, output logic [3:0] gf);
    int n;
    e = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((d_t | d_f) == 4'h0 && n < 30);
    gt = d_t;
    gf = d_f;
    total++;
    if ((d_t | d_f) == 4'h0) begin
      bad++;
      $display("FAIL tok_valid_timeout: rails=%h/%h, want valid", d_t, d_f);
    end
    e = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((d_t | d_f) != 4'h0 && n < 30);
    total++;
    if ((d_t | d_f) != 4'h0) begin
      bad++;
      $display("FAIL tok_neut_timeout: rails=%h/%h, want 0/0", d_t, d_f);
    end
    exp_tok++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    e = 1'b1;
    in_valid = 1'b1;
    in_data = 4'hF;
    loop_en = 1'b0;
    e2 = 1'b1;
    v2 = 1'b0;
    data2 = 4'h0;
    loop2 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (d_t !== 4'h0 || d_f !== 4'h0) begin
      bad++;
      $display("FAIL rst_rails: %h/%h, want 0/0", d_t, d_f);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_ready: %b, want 0", in_ready);
    end
    total++;
    if (tok_count !== 16'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_cnt_busy: tok=%0d busy=%b, want 0 0",
               tok_count, busy);
    end
    in_valid = 1'b0;
    e = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_rst: rdy=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_single_token;
    push_word(4'hA);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy_q: %b, want 1", busy);
    end
    e = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (d_t !== 4'h0 || d_f !== 4'h0) begin
      bad++;
      $display("FAIL single_early: %h/%h, want 0/0", d_t, d_f);
    end
    @(negedge clk);
    total++;
    if (d_t !== 4'hA || d_f !== 4'h5) begin
      bad++;
      $display("FAIL single_valid: %h/%h, want a/5", d_t, d_f);
    end
    e = 1'b0;
    repeat (4) @(negedge clk);
    exp_tok++;
    total++;
    if (d_t !== 4'h0 || d_f !== 4'h0 || tok_count !== 16'(exp_tok)) begin
      bad++;
      $display("FAIL single_neut: %h/%h tok=%0d, want 0/0 tok=%0d",
               d_t, d_f, tok_count, exp_tok);
    end
    e = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy: %b, want 0", busy);
    end
    e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full;
    logic [3:0] gt;
    logic [3:0] gf;
    logic [3:0] w;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      w = 4'(i + 1);
      in_valid = 1'b1;
      in_data = w;
      total++;
      if (in_ready !== (i < 8)) begin
        bad++;
        $display("FAIL full_rdy[%0d]: %b, want %b", i, in_ready, i < 8);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_token(gt, gf);
      w = 4'(i + 1);
      total++;
      if (gt !== w || gf !== ~w) begin
        bad++;
        $display("FAIL full_tok[%0d]: %h/%h, want %h/%h", i, gt, gf, w, ~w);
      end
    end
    total++;
    if (tok_count !== 16'(exp_tok)) begin
      bad++;
      $display("FAIL full_cnt: %0d, want %0d", tok_count, exp_tok);
    end
    e = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || (d_t | d_f) !== 4'h0) begin
      bad++;
      $display("FAIL full_drain: busy=%b rails=%h/%h, want 0 0/0",
               busy, d_t, d_f);
    end
    e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loop;
    logic [3:0] gt;
    logic [3:0] gf;
    logic [3:0] seq [7];
    seq = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3, 4'h1};
    push_word(4'h1);
    push_word(4'h2);
    push_word(4'h3);
    loop_en = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL loop_rdy: %b, want 0", in_ready);
    end
    for (int i = 0; i < 7; i++) begin
      do_token(gt, gf);
      total++;
      if (gt !== seq[i] || gf !== ~seq[i]) begin
        bad++;
        $display("FAIL loop_tok[%0d]: %h/%h, want %h/%h",
                 i, gt, gf, seq[i], ~seq[i]);
      end
    end
    loop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_token(gt, gf);
      total++;
      if (gt !== 4'(i + 1)) begin
        bad++;
        $display("FAIL unloop_tok[%0d]: %h, want %h", i, gt, 4'(i + 1));
      end
    end
    e = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || (d_t | d_f) !== 4'h0 ||
        tok_count !== 16'(exp_tok) || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL loop_drain: busy=%b rails=%h/%h tok=%0d rdy=%b, want 0 0/0 %0d 1",
               busy, d_t, d_f, tok_count, in_ready, exp_tok);
    end
    e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_polarity;
    @(negedge clk);
    v2 = 1'b1;
    data2 = 4'h6;
    @(negedge clk);
    v2 = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (dt2 !== 4'h0 || df2 !== 4'h0) begin
      bad++;
      $display("FAIL pol_hold: %h/%h, want 0/0", dt2, df2);
    end
    e2 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (dt2 !== 4'h6 || df2 !== 4'h9) begin
      bad++;
      $display("FAIL pol_valid: %h/%h, want 6/9", dt2, df2);
    end
    e2 = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (dt2 !== 4'h0 || df2 !== 4'h0 || tok2 !== 16'd1) begin
      bad++;
      $display("FAIL pol_neut: %h/%h tok=%0d, want 0/0 1", dt2, df2, tok2);
    end
    e2 = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (busy2 !== 1'b0) begin
      bad++;
      $display("FAIL pol_busy: %b, want 0", busy2);
    end
    e2 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort;
    push_word(4'hC);
    e = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (d_t !== 4'hC || d_f !== 4'h3) begin
      bad++;
      $display("FAIL abort_valid: %h/%h, want c/3", d_t, d_f);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (d_t !== 4'h0 || d_f !== 4'h0) begin
      bad++;
      $display("FAIL abort_rails: %h/%h, want 0/0", d_t, d_f);
    end
    e = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || tok_count !== 16'd0) begin
      bad++;
      $display("FAIL abort_after: busy=%b rdy=%b tok=%0d, want 0 1 0",
               busy, in_ready, tok_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_token();
    test_full();
    test_loop();
    test_polarity();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
